// File: rtl/reg_file_checker.sv
// Shadow-model checker for a register file: mirrors every write and compares
// each qualified read port against the expected value, with sticky flags and counters.
module reg_file_checker #(
    parameter int DATA_WIDTH   = 32,
    parameter int ADDR_WIDTH   = 5,
    parameter int NUM_RD_PORTS = 2,
    parameter int BYPASS       = 0,
    parameter int CNT_WIDTH    = 16,
    parameter int FATAL_ON_ERR = 0,
    localparam int PORT_W      = (NUM_RD_PORTS > 1) ? $clog2(NUM_RD_PORTS) : 1
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                wr_en,
    input  logic [ADDR_WIDTH-1:0]               wr_reg,
    input  logic [DATA_WIDTH-1:0]               wr_data,
    input  logic [NUM_RD_PORTS-1:0]             rd_valid,
    input  logic [NUM_RD_PORTS*ADDR_WIDTH-1:0]  rd_reg,
    input  logic [NUM_RD_PORTS*DATA_WIDTH-1:0]  rd_data,
    output logic [NUM_RD_PORTS-1:0]             mismatch,
    output logic                                err,
    output logic                                x0_err,
    output logic [CNT_WIDTH-1:0]                err_count,
    output logic [CNT_WIDTH-1:0]                check_count,
    output logic                                fe_valid,
    output logic [PORT_W-1:0]                   fe_port,
    output logic [ADDR_WIDTH-1:0]               fe_addr,
    output logic [DATA_WIDTH-1:0]               fe_expected,
    output logic [DATA_WIDTH-1:0]               fe_actual
);

    localparam int DEPTH = 2**ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] ZERO_ADDR = {ADDR_WIDTH{1'b0}};
    localparam logic [DATA_WIDTH-1:0] ZERO_DATA = {DATA_WIDTH{1'b0}};
    localparam logic [DEPTH-1:0]      VALID_RST = {{(DEPTH-1){1'b0}}, 1'b1};

    function automatic logic [CNT_WIDTH-1:0] sat_add(input logic [CNT_WIDTH-1:0] a,
                                                     input logic [2:0] b);
        logic [CNT_WIDTH+2:0] sum;
        sum = {3'b000, a} + {{CNT_WIDTH{1'b0}}, b};
        if (sum > {3'b000, {CNT_WIDTH{1'b1}}}) begin
            sat_add = {CNT_WIDTH{1'b1}};
        end else begin
            sat_add = sum[CNT_WIDTH-1:0];
        end
    endfunction

    logic [DATA_WIDTH-1:0]  shadow_q [DEPTH];
    logic [DATA_WIDTH-1:0]  shadow_d [DEPTH];
    logic [DEPTH-1:0]       valid_q, valid_d;
    logic                   wr_fire_s;

    logic [ADDR_WIDTH-1:0]  rd_idx_s [NUM_RD_PORTS];
    logic [DATA_WIDTH-1:0]  rd_act_s [NUM_RD_PORTS];
    logic [DATA_WIDTH-1:0]  rd_exp_s [NUM_RD_PORTS];
    logic [NUM_RD_PORTS-1:0] hit_s, chk_s, mis_s, x0_s;
    logic [2:0]             n_chk_s, n_mis_s;
    logic [PORT_W-1:0]      fe_sel_s;

    logic [NUM_RD_PORTS-1:0] mismatch_q, mismatch_d;
    logic                    err_q, err_d, x0_err_q, x0_err_d;
    logic [CNT_WIDTH-1:0]    err_count_q, err_count_d, check_count_q, check_count_d;
    logic                    fe_valid_q, fe_valid_d;
    logic [PORT_W-1:0]       fe_port_q, fe_port_d;
    logic [ADDR_WIDTH-1:0]   fe_addr_q, fe_addr_d;
    logic [DATA_WIDTH-1:0]   fe_expected_q, fe_expected_d, fe_actual_q, fe_actual_d;

    assign wr_fire_s = wr_en && !rst && (wr_reg != ZERO_ADDR);

    // Per-port expectation: index 0 is hardwired zero, a write-first bypass
    // only exists when BYPASS is set, otherwise the pre-edge shadow value.
    for (genvar p = 0; p < NUM_RD_PORTS; p++) begin : g_port
        assign rd_idx_s[p] = rd_reg[p*ADDR_WIDTH +: ADDR_WIDTH];
        assign rd_act_s[p] = rd_data[p*DATA_WIDTH +: DATA_WIDTH];
        assign hit_s[p]    = (BYPASS == 1) && wr_en && (wr_reg == rd_idx_s[p])
                             && (rd_idx_s[p] != ZERO_ADDR);
        assign rd_exp_s[p] = (rd_idx_s[p] == ZERO_ADDR) ? ZERO_DATA :
                             hit_s[p] ? wr_data : shadow_q[rd_idx_s[p]];
        assign chk_s[p]    = !rst && rd_valid[p] && ((rd_idx_s[p] == ZERO_ADDR)
                             || valid_q[rd_idx_s[p]] || hit_s[p]);
        assign mis_s[p]    = chk_s[p] && (rd_act_s[p] != rd_exp_s[p]);
        assign x0_s[p]     = mis_s[p] && (rd_idx_s[p] == ZERO_ADDR);
    end

    // Shadow array and written-valid bits follow every accepted write.
    always_comb begin
        shadow_d = shadow_q;
        valid_d  = valid_q;
        if (wr_fire_s) begin
            shadow_d[wr_reg] = wr_data;
            valid_d[wr_reg]  = 1'b1;
        end else begin
            shadow_d = shadow_q;
            valid_d  = valid_q;
        end
    end

    // Per-cycle counts and lowest-index mismatching port.
    always_comb begin
        n_chk_s  = 3'b000;
        n_mis_s  = 3'b000;
        fe_sel_s = {PORT_W{1'b0}};
        for (int p = 0; p < NUM_RD_PORTS; p++) begin
            n_chk_s = n_chk_s + {2'b00, chk_s[p]};
            n_mis_s = n_mis_s + {2'b00, mis_s[p]};
        end
        for (int p = NUM_RD_PORTS - 1; p >= 0; p--) begin
            fe_sel_s = mis_s[p] ? PORT_W'(p) : fe_sel_s;
        end
    end

    // Next state of the status outputs; the first-error capture freezes once set.
    always_comb begin
        mismatch_d    = mis_s;
        err_d         = err_q | (|mis_s);
        x0_err_d      = x0_err_q | (|x0_s);
        err_count_d   = sat_add(err_count_q, n_mis_s);
        check_count_d = sat_add(check_count_q, n_chk_s);
        fe_valid_d    = fe_valid_q;
        fe_port_d     = fe_port_q;
        fe_addr_d     = fe_addr_q;
        fe_expected_d = fe_expected_q;
        fe_actual_d   = fe_actual_q;
        if (!fe_valid_q && (mis_s != {NUM_RD_PORTS{1'b0}})) begin
            fe_valid_d    = 1'b1;
            fe_port_d     = fe_sel_s;
            fe_addr_d     = rd_idx_s[fe_sel_s];
            fe_expected_d = rd_exp_s[fe_sel_s];
            fe_actual_d   = rd_act_s[fe_sel_s];
        end else begin
            fe_valid_d    = fe_valid_q;
        end
    end

    // Shadow data carries no reset; the valid bits alone decide what is checked.
    always_ff @(posedge clk) begin
        shadow_q <= shadow_d;
    end

    // Control and status state with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q       <= VALID_RST;
            mismatch_q    <= {NUM_RD_PORTS{1'b0}};
            err_q         <= 1'b0;
            x0_err_q      <= 1'b0;
            err_count_q   <= {CNT_WIDTH{1'b0}};
            check_count_q <= {CNT_WIDTH{1'b0}};
            fe_valid_q    <= 1'b0;
            fe_port_q     <= {PORT_W{1'b0}};
            fe_addr_q     <= ZERO_ADDR;
            fe_expected_q <= ZERO_DATA;
            fe_actual_q   <= ZERO_DATA;
        end else begin
            valid_q       <= valid_d | VALID_RST;
            mismatch_q    <= mismatch_d;
            err_q         <= err_d;
            x0_err_q      <= x0_err_d;
            err_count_q   <= err_count_d;
            check_count_q <= check_count_d;
            fe_valid_q    <= fe_valid_d;
            fe_port_q     <= fe_port_d;
            fe_addr_q     <= fe_addr_d;
            fe_expected_q <= fe_expected_d;
            fe_actual_q   <= fe_actual_d;
        end
    end

`ifndef SYNTHESIS
    // Optional hard stop in simulation on the detecting edge.
    always @(posedge clk) begin
        for (int p = 0; p < NUM_RD_PORTS; p++) begin
            if ((FATAL_ON_ERR == 1) && mis_s[p]) begin
                $fatal(1, "reg_file_checker: port %0d x%0d expected %h actual %h",
                       p, rd_idx_s[p], rd_exp_s[p], rd_act_s[p]);
            end
        end
    end
`endif

    assign mismatch    = mismatch_q;
    assign err         = err_q;
    assign x0_err      = x0_err_q;
    assign err_count   = err_count_q;
    assign check_count = check_count_q;
    assign fe_valid    = fe_valid_q;
    assign fe_port     = fe_port_q;
    assign fe_addr     = fe_addr_q;
    assign fe_expected = fe_expected_q;
    assign fe_actual   = fe_actual_q;

endmodule

// File: tb/tb_reg_file_checker.sv
// Bench for reg_file_checker: two instances (write-old/16-bit counters and
// write-first/4-bit counters) share stimulus and are compared to an array-based model.
module tb_reg_file_checker;

    logic        clk = 1'b0;
    logic        rst, wr_en;
    logic [4:0]  wr_reg;
    logic [31:0] wr_data;
    logic [1:0]  rd_valid;
    logic [9:0]  rd_reg;
    logic [63:0] rd_data;

    logic [1:0]  o_mis [2];
    logic        o_err [2], o_x0 [2], o_fev [2], o_fep [2];
    logic [4:0]  o_fea [2];
    logic [31:0] o_fee [2], o_fact [2], o_ec [2], o_cc [2];
    logic [15:0] ec0, cc0;
    logic [3:0]  ec1, cc1;

    assign o_ec[0] = {16'd0, ec0};
    assign o_cc[0] = {16'd0, cc0};
    assign o_ec[1] = {28'd0, ec1};
    assign o_cc[1] = {28'd0, cc1};

    reg_file_checker #(.BYPASS(0), .CNT_WIDTH(16)) dut0 (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_reg(wr_reg), .wr_data(wr_data),
        .rd_valid(rd_valid), .rd_reg(rd_reg), .rd_data(rd_data),
        .mismatch(o_mis[0]), .err(o_err[0]), .x0_err(o_x0[0]),
        .err_count(ec0), .check_count(cc0), .fe_valid(o_fev[0]), .fe_port(o_fep[0]),
        .fe_addr(o_fea[0]), .fe_expected(o_fee[0]), .fe_actual(o_fact[0]));

    reg_file_checker #(.BYPASS(1), .CNT_WIDTH(4)) dut1 (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_reg(wr_reg), .wr_data(wr_data),
        .rd_valid(rd_valid), .rd_reg(rd_reg), .rd_data(rd_data),
        .mismatch(o_mis[1]), .err(o_err[1]), .x0_err(o_x0[1]),
        .err_count(ec1), .check_count(cc1), .fe_valid(o_fev[1]), .fe_port(o_fep[1]),
        .fe_addr(o_fea[1]), .fe_expected(o_fee[1]), .fe_actual(o_fact[1]));

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: written registers live in an associative array.
    logic [31:0] mem [int];
    logic [1:0]  m_mis [2];
    logic        m_err [2], m_x0 [2], m_fev [2], m_fep [2];
    logic [4:0]  m_fea [2];
    logic [31:0] m_fee [2], m_fact [2], m_ec [2], m_cc [2];

    task automatic model_clear();
        for (int c = 0; c < 2; c++) begin
            m_mis[c] = 2'b00; m_err[c] = 1'b0; m_x0[c] = 1'b0; m_fev[c] = 1'b0;
            m_fep[c] = 1'b0; m_fea[c] = 5'd0; m_fee[c] = 32'd0; m_fact[c] = 32'd0;
            m_ec[c] = 32'd0; m_cc[c] = 32'd0;
        end
        mem.delete();
    endtask

    task automatic model_edge();
        logic [4:0]  idx;
        logic [31:0] act, ex, mx;
        bit          chk, mis;
        int          nm, nc;
        if (rst) begin
            model_clear();
            return;
        end
        for (int c = 0; c < 2; c++) begin
            mx = (c == 0) ? 32'd65535 : 32'd15;
            nm = 0; nc = 0; m_mis[c] = 2'b00;
            for (int p = 0; p < 2; p++) begin
                idx = rd_reg[p*5 +: 5];
                act = rd_data[p*32 +: 32];
                chk = 1'b1; ex = 32'd0;
                if (idx == 5'd0) ex = 32'd0;
                else if (c == 1 && wr_en && wr_reg == idx) ex = wr_data;
                else if (mem.exists(int'(idx))) ex = mem[int'(idx)];
                else chk = 1'b0;
                chk = chk && rd_valid[p];
                mis = chk && (act != ex);
                nc += int'(chk);
                nm += int'(mis);
                if (mis) begin
                    m_mis[c][p] = 1'b1;
                    m_err[c] = 1'b1;
                    if (idx == 5'd0) m_x0[c] = 1'b1;
                    if (!m_fev[c]) begin
                        m_fev[c] = 1'b1; m_fep[c] = p[0]; m_fea[c] = idx;
                        m_fee[c] = ex; m_fact[c] = act;
                    end
                end
            end
            m_ec[c] = (m_ec[c] + nm > mx) ? mx : m_ec[c] + nm;
            m_cc[c] = (m_cc[c] + nc > mx) ? mx : m_cc[c] + nc;
        end
        if (wr_en && wr_reg != 5'd0) mem[int'(wr_reg)] = wr_data;
    endtask

    task automatic step();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        rst = 1'b0; wr_en = 1'b0; wr_reg = 5'd0; wr_data = 32'd0;
        rd_valid = 2'b00; rd_reg = 10'd0; rd_data = 64'd0;
    endtask

    task automatic set_rd(input int p, input logic v, input logic [4:0] idx, input logic [31:0] d);
        rd_valid[p] = v;
        rd_reg[p*5 +: 5] = idx;
        rd_data[p*32 +: 32] = d;
    endtask

    task automatic set_wr(input logic [4:0] r, input logic [31:0] d);
        wr_en = 1'b1; wr_reg = r; wr_data = d;
    endtask

    task automatic test_reset();
        idle(); rst = 1'b1; set_wr(5'd5, 32'h1234);
        set_rd(0, 1'b1, 5'd0, 32'hFFFF_FFFF); set_rd(1, 1'b1, 5'd5, 32'h1);
        step(); step();
        for (int c = 0; c < 2; c++) begin
            checks++;
            if (o_mis[c] !== 2'b00 || o_err[c] !== 1'b0 || o_x0[c] !== 1'b0 || o_ec[c] !== 32'd0
                || o_cc[c] !== 32'd0 || o_fev[c] !== 1'b0 || o_fep[c] !== 1'b0 || o_fea[c] !== 5'd0
                || o_fee[c] !== 32'd0 || o_fact[c] !== 32'd0) begin
                errors++;
                $display("FAIL reset c%0d got mis=%0h err=%0b x0=%0b ec=%0d cc=%0d fev=%0b want all zero",
                         c, o_mis[c], o_err[c], o_x0[c], o_ec[c], o_cc[c], o_fev[c]);
            end
        end
        idle();
    endtask

    task automatic test_write_read();
        idle(); set_wr(5'd5, 32'hDEAD_BEEF); step();
        idle(); set_rd(0, 1'b1, 5'd5, 32'hDEAD_BEEF); step();
        for (int c = 0; c < 2; c++) begin
            checks++;
            if (o_mis[c] !== 2'b00 || o_cc[c] !== 32'd1 || o_err[c] !== 1'b0) begin
                errors++;
                $display("FAIL write_read c%0d got mis=%0h cc=%0d err=%0b want 0/1/0",
                         c, o_mis[c], o_cc[c], o_err[c]);
            end
        end
        idle();
    endtask

    task automatic test_x0();
        idle(); set_rd(1, 1'b1, 5'd0, 32'h1); step();
        for (int c = 0; c < 2; c++) begin
            checks++;
            if (o_mis[c] !== 2'b10 || o_err[c] !== 1'b1 || o_x0[c] !== 1'b1) begin
                errors++;
                $display("FAIL x0_flags c%0d got mis=%0h err=%0b x0=%0b want 2/1/1",
                         c, o_mis[c], o_err[c], o_x0[c]);
            end
            checks++;
            if (o_fev[c] !== 1'b1 || o_fep[c] !== 1'b1 || o_fea[c] !== 5'd0
                || o_fee[c] !== 32'd0 || o_fact[c] !== 32'd1) begin
                errors++;
                $display("FAIL x0_capture c%0d got v=%0b port=%0d addr=%0d exp=%0h act=%0h want 1/1/0/0/1",
                         c, o_fev[c], o_fep[c], o_fea[c], o_fee[c], o_fact[c]);
            end
        end
        idle(); step();
        for (int c = 0; c < 2; c++) begin
            checks++;
            if (o_mis[c] !== 2'b00 || o_err[c] !== 1'b1 || o_x0[c] !== 1'b1) begin
                errors++;
                $display("FAIL x0_pulse c%0d got mis=%0h err=%0b x0=%0b want 0/1/1",
                         c, o_mis[c], o_err[c], o_x0[c]);
            end
        end
    endtask

    task automatic test_bypass();
        idle(); rst = 1'b1; step();
        idle(); set_wr(5'd7, 32'h11); step();
        idle(); set_wr(5'd7, 32'hA5); set_rd(0, 1'b1, 5'd7, 32'h11); step();
        checks++;
        if (o_mis[0] !== 2'b00 || o_err[0] !== 1'b0 || o_cc[0] !== 32'd1) begin
            errors++;
            $display("FAIL bypass0 got mis=%0h err=%0b cc=%0d want 0/0/1", o_mis[0], o_err[0], o_cc[0]);
        end
        checks++;
        if (o_mis[1] !== 2'b01 || o_err[1] !== 1'b1 || o_fee[1] !== 32'hA5 || o_fact[1] !== 32'h11) begin
            errors++;
            $display("FAIL bypass1 got mis=%0h err=%0b exp=%0h act=%0h want 1/1/a5/11",
                     o_mis[1], o_err[1], o_fee[1], o_fact[1]);
        end
        idle(); set_wr(5'd9, 32'h99); set_rd(0, 1'b1, 5'd9, 32'h12345); step();
        checks++;
        if (o_mis[0] !== 2'b00 || o_cc[0] !== 32'd1 || o_err[0] !== 1'b0) begin
            errors++;
            $display("FAIL unwritten_bypass0 got mis=%0h cc=%0d err=%0b want 0/1/0", o_mis[0], o_cc[0], o_err[0]);
        end
        checks++;
        if (o_mis[1] !== 2'b01 || o_cc[1] !== 32'd2) begin
            errors++;
            $display("FAIL unwritten_bypass1 got mis=%0h cc=%0d want 1/2", o_mis[1], o_cc[1]);
        end
        idle();
    endtask

    task automatic test_reset_discard();
        idle(); rst = 1'b1; step();
        idle(); set_wr(5'd3, 32'h3333); step();
        idle(); rst = 1'b1; step();
        idle(); set_rd(0, 1'b1, 5'd3, 32'hBAD); step();
        for (int c = 0; c < 2; c++) begin
            checks++;
            if (o_cc[c] !== 32'd0 || o_err[c] !== 1'b0 || o_mis[c] !== 2'b00) begin
                errors++;
                $display("FAIL reset_discard c%0d got cc=%0d err=%0b mis=%0h want 0/0/0",
                         c, o_cc[c], o_err[c], o_mis[c]);
            end
        end
        idle();
    endtask

    task automatic test_saturate();
        idle(); rst = 1'b1; step();
        idle(); set_wr(5'd1, 32'h100); step();
        idle(); set_wr(5'd2, 32'h200); step();
        idle();
        for (int i = 0; i < 20; i++) begin
            set_rd(0, 1'b1, 5'd1, 32'hE000 + i);
            set_rd(1, 1'b1, 5'd2, 32'hF000 + i);
            step();
        end
        idle(); step();
        checks++;
        if (o_ec[1] !== 32'd15 || o_cc[1] !== 32'd15) begin
            errors++;
            $display("FAIL sat_cnt4 got ec=%0d cc=%0d want 15/15", o_ec[1], o_cc[1]);
        end
        checks++;
        if (o_ec[0] !== 32'd40 || o_cc[0] !== 32'd40) begin
            errors++;
            $display("FAIL sat_cnt16 got ec=%0d cc=%0d want 40/40", o_ec[0], o_cc[0]);
        end
        for (int c = 0; c < 2; c++) begin
            checks++;
            if (o_fev[c] !== 1'b1 || o_fep[c] !== 1'b0 || o_fea[c] !== 5'd1
                || o_fee[c] !== 32'h100 || o_fact[c] !== 32'hE000) begin
                errors++;
                $display("FAIL sat_first c%0d got v=%0b port=%0d addr=%0d exp=%0h act=%0h want 1/0/1/100/e000",
                         c, o_fev[c], o_fep[c], o_fea[c], o_fee[c], o_fact[c]);
            end
        end
    endtask

    task automatic test_random();
        logic [4:0]  idx;
        logic [31:0] d;
        idle(); rst = 1'b1; step();
        for (int i = 0; i < 400; i++) begin
            rst     = ($urandom_range(0, 49) == 0);
            wr_en   = $urandom_range(0, 1) == 1;
            wr_reg  = 5'($urandom_range(0, 7));
            wr_data = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 3));
            for (int p = 0; p < 2; p++) begin
                idx = 5'($urandom_range(0, 7));
                if ($urandom_range(0, 4) == 0) d = 32'($urandom_range(0, 3));
                else if (idx == 5'd0) d = 32'd0;
                else if (wr_en && wr_reg == idx && $urandom_range(0, 1) == 1) d = wr_data;
                else if (mem.exists(int'(idx))) d = mem[int'(idx)];
                else d = $urandom;
                set_rd(p, $urandom_range(0, 3) != 0, idx, d);
            end
            step();
            for (int c = 0; c < 2; c++) begin
                checks++;
                if (o_mis[c] !== m_mis[c] || o_err[c] !== m_err[c] || o_x0[c] !== m_x0[c]) begin
                    errors++;
                    $display("FAIL rnd_flags c%0d cyc%0d got mis=%0h err=%0b x0=%0b want mis=%0h err=%0b x0=%0b",
                             c, i, o_mis[c], o_err[c], o_x0[c], m_mis[c], m_err[c], m_x0[c]);
                end
                checks++;
                if (o_ec[c] !== m_ec[c] || o_cc[c] !== m_cc[c]) begin
                    errors++;
                    $display("FAIL rnd_counts c%0d cyc%0d got ec=%0d cc=%0d want ec=%0d cc=%0d",
                             c, i, o_ec[c], o_cc[c], m_ec[c], m_cc[c]);
                end
                checks++;
                if (o_fev[c] !== m_fev[c] || o_fep[c] !== m_fep[c] || o_fea[c] !== m_fea[c]
                    || o_fee[c] !== m_fee[c] || o_fact[c] !== m_fact[c]) begin
                    errors++;
                    $display("FAIL rnd_capture c%0d cyc%0d got %0b/%0d/%0d/%0h/%0h want %0b/%0d/%0d/%0h/%0h",
                             c, i, o_fev[c], o_fep[c], o_fea[c], o_fee[c], o_fact[c],
                             m_fev[c], m_fep[c], m_fea[c], m_fee[c], m_fact[c]);
                end
            end
        end
        idle();
    endtask

    initial begin
        model_clear();
        idle();
        test_reset();
        test_write_read();
        test_x0();
        test_bypass();
        test_reset_discard();
        test_saturate();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/reg_file_checker.md
REG_FILE_CHECKER -- requirements
Module: reg_file_checker

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 32, meaning register data width in bits.
REQ-002 The block SHALL have parameter ADDR_WIDTH, default 5, meaning register index width; depth = 2**ADDR_WIDTH.
REQ-003 The block SHALL have parameter NUM_RD_PORTS, default 2, meaning number of monitored read ports (1..4).
REQ-004 The block SHALL have parameter BYPASS, default 0, meaning 1 = same-cycle write is visible on read (write-first), 0 = read returns old value.
REQ-005 The block SHALL have parameter CNT_WIDTH, default 16, meaning width of the saturating counters.
REQ-006 The block SHALL have parameter FATAL_ON_ERR, default 0, meaning 1 = simulation $fatal on any mismatch.
REQ-007 The block SHALL have port clk  in  1  single clock, all state updates on the rising edge.
REQ-008 The block SHALL have port rst  in  1  reset, synchronous, active-high.
REQ-009 The block SHALL have port wr_en  in  1  write strobe of the observed register file.
REQ-010 The block SHALL have port wr_reg  in  ADDR_WIDTH  write index.
REQ-011 The block SHALL have port wr_data  in  DATA_WIDTH  write data.
REQ-012 The block SHALL have port rd_valid  in  NUM_RD_PORTS  per-port read qualifier.
REQ-013 The block SHALL have port rd_reg  in  NUM_RD_PORTS*ADDR_WIDTH  packed read indices, port p at bits [p*ADDR_WIDTH +: ADDR_WIDTH].
REQ-014 The block SHALL have port rd_data  in  NUM_RD_PORTS*DATA_WIDTH  packed DUT read data, same packing.
REQ-015 The block SHALL have port mismatch  out  NUM_RD_PORTS  per-port one-cycle error pulse.
REQ-016 The block SHALL have port err  out  1  sticky any-error flag.
REQ-017 The block SHALL have port x0_err  out  1  sticky flag: nonzero data read from index 0.
REQ-018 The block SHALL have ports err_count and check_count  out  CNT_WIDTH  saturating mismatch and checked-read counts.
REQ-019 The block SHALL have ports fe_valid (1), fe_port ($clog2(NUM_RD_PORTS) min 1), fe_addr (ADDR_WIDTH), fe_expected and fe_actual (DATA_WIDTH), all out, holding the first-error capture.

Function
REQ-020 The block SHALL keep a shadow array of depth entries plus one written-valid bit per entry; entry 0 SHALL read as 0 and count as valid at all times.
REQ-021 On a rising edge with wr_en=1, rst=0, wr_reg!=0, the block SHALL set shadow[wr_reg]=wr_data and its valid bit; writes to index 0 SHALL be ignored.
REQ-022 Expected value for port p SHALL be: 0 if rd_reg_p==0; else wr_data if BYPASS==1, wr_en=1, wr_reg==rd_reg_p; else shadow[rd_reg_p] (pre-edge value).
REQ-023 Port p SHALL be checked in a cycle iff rd_valid[p]=1 and (rd_reg_p==0, the entry is valid, or the BYPASS hit of REQ-022 applies); unwritten entries SHALL NOT be checked.
REQ-024 With BYPASS==0, a same-cycle write and read of an unwritten index SHALL leave that read unchecked.
REQ-025 A checked port with rd_data_p != expected SHALL drive mismatch[p]=1 for exactly the cycle after the sampling edge (1-cycle latency); otherwise mismatch[p]=0.
REQ-026 err SHALL set on the edge any mismatch is detected and hold until rst; x0_err likewise for mismatches with rd_reg_p==0.
REQ-027 err_count SHALL add the number of mismatching ports that cycle, check_count the number of checked ports; both SHALL saturate at 2**CNT_WIDTH-1, never wrap.
REQ-028 On the first mismatch cycle after reset, the block SHALL capture the lowest-index mismatching port into fe_port/fe_addr/fe_expected/fe_actual and set fe_valid; capture SHALL NOT change until rst.
REQ-029 If FATAL_ON_ERR==1, the block SHALL call $fatal with port, index, expected and actual in the detecting cycle; synthesis SHALL ignore this.

Reset
REQ-030 While rst=1 at an edge, all outputs SHALL clear to 0, all valid bits except entry 0 clear, no check or write SHALL occur; rst SHALL dominate any same-cycle wr_en or rd_valid.
REQ-031 Reset asserted mid-operation SHALL discard pending shadow contents; subsequent reads of previously written indices SHALL be unchecked until rewritten.

Verification
REQ-032 Bench SHALL cover: write x5=0xDEADBEEF, next cycle read port0 x5 returning 0xDEADBEEF -> mismatch=0, check_count=1, err=0.
REQ-033 Bench SHALL cover: read port1 x0 returning 0x1 -> mismatch=2'b10 one cycle, err=1, x0_err=1, fe_port=1, fe_addr=0, fe_expected=0, fe_actual=1.
REQ-034 Bench SHALL cover: BYPASS=0 vs 1, same-cycle write x7=0xA5 (old 0x11) with read x7 returning 0x11 -> no error for BYPASS=0, mismatch for BYPASS=1.
REQ-035 Bench SHALL cover: CNT_WIDTH=4, 20 mismatching reads on both ports -> err_count holds 15; fe_* equals the first error only.
REQ-036 Bench SHALL cover: write x3, assert rst one cycle, read x3 returning garbage -> unchecked, check_count=0, err=0.
